// File: rtl/toeplitz_sched.sv
// rtl/toeplitz_sched.sv - ping-pong block buffer scheduler feeding a serial toeplitz extractor core
// Fills two N-bit buffers from a bit stream, streams each full block MSB first, returns the L-bit result.
module toeplitz_sched #(
  parameter int N   = 256,
  parameter int L   = 128,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         core_reset,
  output logic         core_data,
  input  logic [L-1:0] core_q,
  input  logic         core_qstrobe,
  output logic [L-1:0] out_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_timeout,
  output logic [15:0]  blk_count
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(N);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, CRST, STREAM, WAIT, OUT} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  bufs [2];
  logic [1:0]    full;
  logic          wr_sel, rd_sel;
  logic [CW-1:0] wr_cnt;
  logic [SW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt;
  logic          rst_hold;
  logic          fill_fire, fill_done;
  logic          free_buf, got_q, timeout, out_fire;
  logic          nx_bit;

  // in_ready depends only on registered fill state, never on the output side
  assign in_ready  = !full[wr_sel] && !reset;
  assign fill_fire = in_valid && in_ready;
  assign fill_done = fill_fire && (wr_cnt == CW'(N - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    free_buf = 1'b0;
    got_q    = 1'b0;
    timeout  = 1'b0;
    out_fire = 1'b0;
    case (state)
      IDLE:   if (full[rd_sel]) state_nx = CRST;
      CRST: begin
        state_nx = STREAM;
        cnt_nx   = '0;
      end
      STREAM: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == SW'(N - 1)) begin
          free_buf = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (core_qstrobe) begin
          got_q    = 1'b1;
          state_nx = OUT;
        end else if (tcnt == TW'(TMO - 1)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_fire = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    nx_bit = bufs[rd_sel][SW'(N - 1) - cnt_nx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      full        <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      wr_cnt      <= '0;
      bufs[0]     <= '0;
      bufs[1]     <= '0;
      rst_hold    <= 1'b1;
      core_reset  <= 1'b1;
      core_data   <= 1'b0;
      out_q       <= '0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      blk_count   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rst_hold   <= 1'b0;
      // core pins are registered from next-state so they line up with the state register
      core_reset <= rst_hold || (state_nx == CRST);
      core_data  <= (state_nx == STREAM) ? nx_bit : 1'b0;
      tcnt       <= (state == WAIT) ? tcnt + 1'b1 : '0;

      if (fill_fire) begin
        bufs[wr_sel] <= {bufs[wr_sel][N-2:0], in_bit};
        if (fill_done) begin
          wr_cnt <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // fill and free never target the same buffer, so both can land in one cycle
      if (fill_done) full[wr_sel] <= 1'b1;
      if (free_buf) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end

      if (got_q) begin
        out_q     <= core_q;
        out_valid <= 1'b1;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        blk_count <= blk_count + 1'b1;
      end
      if (timeout) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toeplitz_sched.sv
// tb/tb_toeplitz_sched.sv - scoreboard bench for toeplitz_sched with a behavioural core model
module tb_toeplitz_sched;
  localparam int N = 256, L = 128, TMO = 16;

  logic         clk = 1'b0, reset = 1'b1;
  logic         in_bit = 1'b0, in_valid = 1'b0, core_qstrobe = 1'b0, out_ready = 1'b0;
  logic [L-1:0] core_q = '0;
  logic         in_ready, core_reset, core_data, out_valid, err_timeout;
  logic [L-1:0] out_q;
  logic [15:0]  blk_count;

  int tests_run = 0, tests_failed = 0;

  always #5 clk = ~clk;

  toeplitz_sched #(.N(N), .L(L), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .core_reset(core_reset), .core_data(core_data), .core_q(core_q), .core_qstrobe(core_qstrobe),
    .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
    .err_timeout(err_timeout), .blk_count(blk_count)
  );

  logic         exp_bits [$];
  logic [L-1:0] exp_q [$];
  logic [N-1:0] cur_blk = '0;
  int           acc_cnt = 0, cyc = 0, n_out = 0;

  logic         m_prev = 1'b0, m_active = 1'b0, strobe_en = 1'b1, pend = 1'b0, m_exp;
  int           m_cnt = 0, dly = 3, pend_cnt = 0, m_last_cyc = -1, m_starts = 0;
  logic [N-1:0] m_sh = '0;
  logic [L-1:0] pend_q = '0, sb_exp, prev_q = '0;
  logic         prev_stall = 1'b0;
  logic [N-1:0] nr [4];

  // Stand-in extractor: any fixed, order-sensitive L-bit function of the block
  function automatic logic [L-1:0] fold(input logic [N-1:0] x);
    return x[N-1:L] ^ {x[0], x[L-1:1]};
  endfunction

  // Core model: a rising core_reset starts a capture of N bits, then strobes after dly cycles
  always @(posedge clk) begin
    #1;
    cyc++;
    core_qstrobe = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        core_qstrobe = 1'b1;
        core_q = pend_q;
        pend = 1'b0;
      end else pend_cnt--;
    end
    if (core_reset) begin
      if (!m_prev) m_starts++;
      m_active = !m_prev;
      m_cnt = 0;
      pend = 1'b0;
    end else if (m_active) begin
      m_sh = {m_sh[N-2:0], core_data};
      tests_run++;
      if (exp_bits.size() == 0) begin
        tests_failed++;
        $display("FAIL bit_order: core_data=%0b streamed with no input bit outstanding", core_data);
      end else begin
        m_exp = exp_bits.pop_front();
        if (core_data !== m_exp) begin
          tests_failed++;
          $display("FAIL bit_order: core_data=%0b, expected %0b at stream index %0d", core_data, m_exp, m_cnt);
        end
      end
      m_cnt++;
      if (m_cnt == N) begin
        m_active = 1'b0;
        m_last_cyc = cyc;
        if (strobe_en) begin
          pend = 1'b1;
          pend_cnt = dly;
          pend_q = fold(m_sh);
        end
      end
    end
    m_prev = core_reset;
  end

  // Output scoreboard and hold-stability monitor
  always @(negedge clk) begin
    if (prev_stall && !reset) begin
      tests_run++;
      if (!out_valid || out_q !== prev_q) begin
        tests_failed++;
        $display("FAIL out_hold: out_valid=%0b out_q=%h, expected held 1/%h", out_valid, out_q, prev_q);
      end
    end
    if (out_valid && out_ready && !reset) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL out_q: got %h with no result expected", out_q);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_q !== sb_exp) begin
          tests_failed++;
          $display("FAIL out_q: got %h, expected %h", out_q, sb_exp);
        end
      end
      n_out++;
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_q = out_q;
  end

  task automatic send_bit(input logic b, input int duty);
    int  guard = 0;
    bit  done = 0;
    while (!done) begin
      @(posedge clk); #1;
      in_bit = b;
      in_valid = ($urandom_range(99) < duty);
      @(negedge clk);
      if (in_valid && in_ready) begin
        done = 1;
        exp_bits.push_back(b);
        cur_blk = {cur_blk[N-2:0], b};
        acc_cnt++;
        if (acc_cnt % N == 0) exp_q.push_back(fold(cur_blk));
      end else if (++guard > 3000) begin
        tests_run++; tests_failed++;
        $display("FAIL in_accept: in_ready stuck at %0b, required 1 within 3000 cycles", in_ready);
        done = 1;
      end
    end
  endtask

  task automatic send_block(input logic [N-1:0] blk, input int duty);
    for (int i = N - 1; i >= 0; i--) send_bit(blk[i], duty);
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget, input string name);
    int k = 0;
    while (n_out < target && k < budget) begin @(negedge clk); k++; end
    tests_run++;
    if (n_out < target) begin
      tests_failed++;
      $display("FAIL %s: %0d results delivered, required %0d", name, n_out, target);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (core_reset !== 1'b1 || core_data !== 1'b0 || out_valid !== 1'b0 || out_q !== '0 ||
        in_ready !== 1'b0 || err_timeout !== 1'b0 || blk_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: cr=%0b cd=%0b ov=%0b oq=%h ir=%0b err=%0b blk=%0d, required 1/0/0/0/0/0/0",
               core_reset, core_data, out_valid, out_q, in_ready, err_timeout, blk_count);
    end
    repeat (2) @(negedge clk);
    exp_bits.delete(); exp_q.delete();
    acc_cnt = 0; cur_blk = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || core_reset !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%0b core_reset=%0b, required 1/1", in_ready, core_reset);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (core_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL core_reset_release: core_reset=%0b, required 0", core_reset);
    end
  endtask

  task automatic test_zero_block();
    int s0 = m_starts;
    int n0 = n_out;
    @(posedge clk); #1; out_ready = 1'b1;
    send_block('0, 100);
    idle_in();
    @(negedge clk);
    tests_run++;
    if (core_reset !== 1'b0) begin
      tests_failed++; $display("FAIL crst_latency0: core_reset=%0b, required 0", core_reset);
    end
    @(negedge clk);
    tests_run++;
    if (core_reset !== 1'b1) begin
      tests_failed++; $display("FAIL crst_latency1: core_reset=%0b, required 1", core_reset);
    end
    wait_outs(n0 + 1, 1000, "zero_result");
    @(negedge clk);
    tests_run++;
    if (blk_count !== 16'd1 || out_q !== '0 || m_starts - s0 != 1) begin
      tests_failed++;
      $display("FAIL zero_block: blk=%0d out_q=%h crst_pulses=%0d, required 1/0/1", blk_count, out_q, m_starts - s0);
    end
  endtask

  task automatic test_midstream_reset();
    int k = 0;
    int n0;
    logic [N-1:0] blk = {8{$urandom()}};
    send_block(blk, 100);
    idle_in();
    while (!(m_active && m_cnt >= 101) && k < 1000) begin @(negedge clk); k++; end
    tests_run++;
    if (!(m_active && m_cnt >= 101)) begin
      tests_failed++; $display("FAIL stream_start: streamed %0d bits, required 101", m_cnt);
    end
    apply_reset();
    n0 = n_out;
    blk = {8{$urandom()}};
    k = m_starts;
    send_block(blk, 100);
    idle_in();
    wait_outs(n0 + 1, 1000, "post_reset_result");
    @(negedge clk);
    tests_run++;
    if (blk_count !== 16'd1 || m_starts - k != 1) begin
      tests_failed++;
      $display("FAIL post_reset_block: blk=%0d crst_pulses=%0d, required 1/1", blk_count, m_starts - k);
    end
  endtask

  task automatic test_back_to_back();
    int base = acc_cnt;
    int n0 = n_out;
    int stall_at = -1;
    logic [15:0] b0 = blk_count;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < N / 32; w++) nr[b][w*32 +: 32] = $urandom();
    @(posedge clk); #1; out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_block(nr[b], 100);
        idle_in();
      end
      begin
        int k = 0;
        while (!out_valid && k < 2000) begin @(negedge clk); k++; end
        repeat (300) @(negedge clk);
        tests_run++;
        if (acc_cnt - base != 3 * N || in_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL backpressure: accepted %0d in_ready=%0b, required %0d/0", acc_cnt - base, in_ready, 3 * N);
        end
        @(posedge clk); #1; out_ready = 1'b1;
      end
      begin
        int k = 0;
        while (acc_cnt - base < 4 * N && k < 6000) begin
          @(negedge clk); k++;
          if (stall_at < 0 && in_valid && !in_ready) stall_at = acc_cnt - base;
        end
      end
    join
    tests_run++;
    if (stall_at != 2 * N) begin
      tests_failed++; $display("FAIL first_stall: in_ready fell after %0d bits, required %0d", stall_at, 2 * N);
    end
    wait_outs(n0 + 4, 3000, "b2b_results");
    @(negedge clk);
    tests_run++;
    if (blk_count !== b0 + 16'd4) begin
      tests_failed++; $display("FAIL b2b_count: blk=%0d, required %0d", blk_count, b0 + 16'd4);
    end
  endtask

  task automatic test_random_duty();
    int n0 = n_out;
    logic [15:0] b0 = blk_count;
    dly = TMO - 1;
    @(posedge clk); #1; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) send_block({8{$urandom()}}, 30);
    idle_in();
    wait_outs(n0 + 2, 2000, "random_duty_results");
    @(negedge clk);
    tests_run++;
    if (blk_count !== b0 + 16'd2 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_strobe: blk=%0d err=%0b, required %0d/0", blk_count, err_timeout, b0 + 16'd2);
    end
    dly = 3;
  endtask

  task automatic test_timeout();
    int k = 0;
    int n0 = n_out;
    logic [15:0] b0 = blk_count;
    strobe_en = 1'b0;
    m_last_cyc = -1;
    send_block({8{$urandom()}}, 100);
    idle_in();
    while (m_last_cyc < 0 && k < 1000) begin @(negedge clk); k++; end
    while (m_last_cyc >= 0 && cyc < m_last_cyc + TMO) @(negedge clk);
    tests_run++;
    if (err_timeout !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_early: err_timeout=%0b at %0d cycles, required 0", err_timeout, TMO);
    end
    @(negedge clk);
    tests_run++;
    if (err_timeout !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_set: err=%0b out_valid=%0b at %0d cycles, required 1/0", err_timeout, out_valid, TMO + 1);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    strobe_en = 1'b1;
    send_block({8{$urandom()}}, 100);
    idle_in();
    wait_outs(n0 + 1, 1000, "after_timeout_result");
    @(negedge clk);
    tests_run++;
    if (err_timeout !== 1'b1 || blk_count !== b0 + 16'd1) begin
      tests_failed++;
      $display("FAIL after_timeout: err=%0b blk=%0d, required 1/%0d", err_timeout, blk_count, b0 + 16'd1);
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_midstream_reset();
    test_back_to_back();
    test_random_duty();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
